// File: rtl/sipo_frame_rx_if.sv
// Parallel output channel of the serial frame receiver: a one-entry valid/ready word buffer
// with per-word parity and framing error flags.
interface sipo_frame_rx_if #(
  parameter int unsigned Width = 8
) ();
  logic [Width-1:0] p_out;
  logic             p_valid;
  logic             p_ready;
  logic             p_perr;
  logic             p_ferr;

  modport master (
    output p_out,
    output p_valid,
    output p_perr,
    output p_ferr,
    input  p_ready
  );

  modport slave (
    input  p_out,
    input  p_valid,
    input  p_perr,
    input  p_ferr,
    output p_ready
  );
endinterface

// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, Width data bits LSB-first, optional parity,
// stop bit; completed frames land in a one-entry valid/ready buffer, dropped if it is full.
module sipo_frame_rx #(
  parameter int unsigned Width     = 8,
  parameter bit          ParityEn  = 1'b1,
  parameter bit          ParityOdd = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              bit_en_i,
  input  logic              s_in_i,
  output logic              overrun_o,
  output logic              busy_o,
  sipo_frame_rx_if.master   p_if
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [CntW-1:0] CntMax = CntW'(Width - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             perr_q, perr_d;
  logic [Width-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             operr_q, operr_d;
  logic             oferr_q, oferr_d;
  logic             overrun_q, overrun_d;
  logic             frame_done;
  logic             load;

  // Frame FSM; every move is gated by the bit strobe.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    perr_d     = perr_q;
    frame_done = 1'b0;
    if (bit_en_i) begin
      unique case (state_q)
        StIdle: begin
          if (s_in_i) begin
            state_d = StData;
            shift_d = '0;
            cnt_d   = '0;
            perr_d  = 1'b0;
          end
        end
        StData: begin
          shift_d = {s_in_i, shift_q[Width-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CntMax) begin
            state_d = ParityEn ? StParity : StStop;
          end
        end
        StParity: begin
          perr_d  = ((^shift_q) ^ s_in_i) != ParityOdd;
          state_d = StStop;
        end
        StStop: begin
          frame_done = 1'b1;
          state_d    = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A completed frame loads if the buffer is empty or drains on this same edge.
  always_comb begin
    load      = frame_done && (!valid_q || p_if.p_ready);
    valid_d   = valid_q;
    data_d    = data_q;
    operr_d   = operr_q;
    oferr_d   = oferr_q;
    overrun_d = frame_done && !load;
    if (load) begin
      valid_d = 1'b1;
      data_d  = shift_q;
      operr_d = ParityEn & perr_q;
      oferr_d = s_in_i;
    end else if (valid_q && p_if.p_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      cnt_q     <= '0;
      perr_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      operr_q   <= 1'b0;
      oferr_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      perr_q    <= perr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      operr_q   <= operr_d;
      oferr_q   <= oferr_d;
      overrun_q <= overrun_d;
    end
  end

  assign p_if.p_out   = data_q;
  assign p_if.p_valid = valid_q;
  assign p_if.p_perr  = operr_q;
  assign p_if.p_ferr  = oferr_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx: directed scenarios then random frames, compared
// against a frame-level model of the output buffer.
module tb_sipo_frame_rx;
  localparam int unsigned Width     = 8;
  localparam bit          ParityEn  = 1'b1;
  localparam bit          ParityOdd = 1'b0;

  logic clk;
  logic rst_ni;
  logic bit_en;
  logic s_in;
  logic overrun;
  logic busy;

  sipo_frame_rx_if #(.Width(Width)) p_if ();

  sipo_frame_rx #(
    .Width    (Width),
    .ParityEn (ParityEn),
    .ParityOdd(ParityOdd)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .bit_en_i (bit_en),
    .s_in_i   (s_in),
    .overrun_o(overrun),
    .busy_o   (busy),
    .p_if     (p_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: held word, expected status, and the frame currently on the line.
  logic             m_valid;
  logic [Width-1:0] m_data;
  logic             m_perr;
  logic             m_ferr;
  logic             m_busy;
  logic             exp_over;
  logic [Width-1:0] cur_data;
  logic             cur_perr;
  logic             cur_ferr;
  int               rdy_mode;   // 0: ready low, 1: ready high, 2: random
  logic             force_rdy;
  int               spacing;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("p_valid", {31'd0, p_if.p_valid}, {31'd0, m_valid});
    chk("overrun", {31'd0, overrun}, {31'd0, exp_over});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    if (m_valid) begin
      chk("p_out", 32'(p_if.p_out), 32'(m_data));
      chk("p_perr", {31'd0, p_if.p_perr}, {31'd0, m_perr});
      chk("p_ferr", {31'd0, p_if.p_ferr}, {31'd0, m_ferr});
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
  task automatic step(input logic be, input logic sin, input logic done, input logic busy_exp);
    logic rdy;
    if (force_rdy)          rdy = 1'b1;
    else if (rdy_mode == 2) rdy = 1'($urandom_range(0, 1));
    else                    rdy = (rdy_mode == 1);
    bit_en         = be;
    s_in           = sin;
    p_if.p_ready   = rdy;
    @(posedge clk);
    if (done) begin
      if (!m_valid || rdy) begin
        m_valid  = 1'b1;
        m_data   = cur_data;
        m_perr   = cur_perr;
        m_ferr   = cur_ferr;
        exp_over = 1'b0;
      end else begin
        exp_over = 1'b1;
      end
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      exp_over = 1'b0;
    end
    m_busy = busy_exp;
    #1;
    check_outputs();
  endtask

  // Bit strobe preceded by spacing-1 non-strobe clocks.
  task automatic strobe(input logic sin, input logic done, input logic busy_exp);
    for (int g = 1; g < spacing; g++) step(1'b0, sin, 1'b0, m_busy);
    step(1'b1, sin, done, busy_exp);
  endtask

  task automatic send_frame(input logic [Width-1:0] d, input logic pbit, input logic stop,
                            input logic stop_ready);
    int ones;
    ones     = $countones(d) + (ParityEn ? int'(pbit) : 0);
    cur_data = d;
    cur_perr = ParityEn ? ((ones % 2 == 1) != ParityOdd) : 1'b0;
    cur_ferr = stop;
    strobe(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < int'(Width); i++) strobe(d[i], 1'b0, 1'b1);
    if (ParityEn) strobe(pbit, 1'b0, 1'b1);
    force_rdy = stop_ready;
    strobe(stop, 1'b1, 1'b0);
    force_rdy = 1'b0;
  endtask

  function automatic logic good_parity(input logic [Width-1:0] d);
    return (^d) ^ ParityOdd;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [Width-1:0] rd;
    rst_ni       = 1'b0;
    bit_en       = 1'b0;
    s_in         = 1'b0;
    p_if.p_ready = 1'b0;
    m_valid      = 1'b0;
    m_data       = '0;
    m_perr       = 1'b0;
    m_ferr       = 1'b0;
    m_busy       = 1'b0;
    exp_over     = 1'b0;
    cur_data     = '0;
    cur_perr     = 1'b0;
    cur_ferr     = 1'b0;
    rdy_mode     = 1;
    force_rdy    = 1'b0;
    spacing      = 1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p_valid", {31'd0, p_if.p_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_p_out", 32'(p_if.p_out), 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_ni = 1'b1;

    // Idle line holds the FSM idle
    idle(20);

    // Clean frame, consumer always ready
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Parity error then framing error, both delivered
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    idle(2);
    send_frame(8'h81, good_parity(8'h81), 1'b1, 1'b0);
    idle(3);

    // Buffer full: second frame dropped with overrun pulse
    rdy_mode = 0;
    send_frame(8'h11, good_parity(8'h11), 1'b0, 1'b0);
    idle(2);
    send_frame(8'h22, good_parity(8'h22), 1'b0, 1'b0);
    idle(3);
    rdy_mode = 1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    rdy_mode = 0;
    idle(3);

    // Ready on the exact stop-sample edge: drain and reload together
    send_frame(8'h11, good_parity(8'h11), 1'b0, 1'b0);
    idle(2);
    send_frame(8'h33, good_parity(8'h33), 1'b0, 1'b1);
    idle(2);
    rdy_mode = 1;
    idle(3);

    // Sparse strobes, async reset mid-frame, then a full frame
    spacing = 4;
    strobe(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) strobe(((8'h5A >> i) & 8'h01) != 0, 1'b0, 1'b1);
    rst_ni = 1'b0;
    #1;
    m_valid  = 1'b0;
    m_busy   = 1'b0;
    exp_over = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_p_valid", {31'd0, p_if.p_valid}, 32'd0);
    #2;
    rst_ni = 1'b1;
    send_frame(8'h5A, good_parity(8'h5A), 1'b0, 1'b0);
    idle(4);

    // Random frames: random data, parity errors, stop errors, strobe spacing, ready
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      spacing = int'($urandom_range(1, 3));
      rd      = Width'($urandom);
      send_frame(rd, good_parity(rd) ^ ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 4) == 0, 1'b0);
      idle(int'($urandom_range(0, 3)));
    end
    rdy_mode = 1;
    spacing  = 1;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
